// File: rtl/writeback_stage_pkg.sv
// Shared datapath width and the writeback/load-size encodings used by the
// writeback stage and by any other stage that aligns load data.
package common;

    localparam int unsigned OPERAND_WIDTH = 32;

    // Writeback source select; the unused code 2'b11 is treated as ALU.
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    // Load size in RISC-V funct3 encoding; codes 011/110/111 behave as LW.
    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } load_size_e;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of a raw
// 32-bit memory word, sign- or zero-extends it, and flags misaligned accesses.
module load_align
    import common::*;
(
    input  logic [31:0] mem_data,
    input  logic [1:0]  off,
    input  logic [2:0]  load_size,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection by byte offset within the word.
    always_comb begin
        byte_sel = mem_data[7:0];
        case (off)
            2'd0:    byte_sel = mem_data[7:0];
            2'd1:    byte_sel = mem_data[15:8];
            2'd2:    byte_sel = mem_data[23:16];
            default: byte_sel = mem_data[31:24];
        endcase
        half_sel = off[1] ? mem_data[31:16] : mem_data[15:0];
    end

    // Extension and alignment check by load size.
    always_comb begin
        data       = mem_data;
        misaligned = 1'b0;
        case (load_size)
            LS_B:  data = {{24{byte_sel[7]}}, byte_sel};
            LS_BU: data = {24'd0, byte_sel};
            LS_H: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = off[0];
            end
            LS_HU: begin
                data       = {16'd0, half_sel};
                misaligned = off[0];
            end
            default: begin
                data       = mem_data;
                misaligned = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback pipeline register: captures the memory-stage result, aligns load
// data, selects the writeback value, and counts instructions entering WB.
module writeback_stage
    import common::*;
#(
    parameter int unsigned OPERAND_WIDTH = common::OPERAND_WIDTH,
    parameter int unsigned CNT_WIDTH     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     ctrl_reg_write,
    input  logic [1:0]               ctrl_wb_sel,
    input  logic [2:0]               ctrl_load_size,
    input  logic [4:0]               rd_addr,
    input  logic [OPERAND_WIDTH-1:0] alu_result,
    input  logic [31:0]              mem_data,
    input  logic [OPERAND_WIDTH-1:0] pc_plus4,
    output logic                     wb_valid,
    output logic                     wb_reg_write,
    output logic [4:0]               wb_rd,
    output logic [OPERAND_WIDTH-1:0] wb_data,
    output logic                     load_misaligned,
    output logic [CNT_WIDTH-1:0]     instr_count
);

    logic [31:0]              ld_data;
    logic                     ld_misaligned;
    logic                     mis_load;
    logic [OPERAND_WIDTH-1:0] wb_value;

    logic                     valid_d,     valid_q;
    logic                     reg_write_d, reg_write_q;
    logic [4:0]               rd_d,        rd_q;
    logic [OPERAND_WIDTH-1:0] data_d,      data_q;
    logic                     mis_d,       mis_q;
    logic [CNT_WIDTH-1:0]     cnt_d,       cnt_q;

    load_align u_load_align (
        .mem_data   (mem_data),
        .off        (alu_result[1:0]),
        .load_size  (ctrl_load_size),
        .data       (ld_data),
        .misaligned (ld_misaligned)
    );

    // Writeback source mux; misalignment only matters for memory loads.
    always_comb begin
        mis_load = (ctrl_wb_sel == WB_MEM) && ld_misaligned;
        case (ctrl_wb_sel)
            WB_MEM:  wb_value = OPERAND_WIDTH'(ld_data);
            WB_PC4:  wb_value = pc_plus4;
            default: wb_value = alu_result;
        endcase
    end

    // Next-state: capture when not stalled; flush squashes even under stall.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        data_d      = data_q;
        mis_d       = mis_q;
        cnt_d       = cnt_q;
        if (!stall) begin
            valid_d     = in_valid;
            reg_write_d = in_valid && ctrl_reg_write && (rd_addr != 5'd0) && !mis_load;
            rd_d        = rd_addr;
            data_d      = wb_value;
            mis_d       = in_valid && mis_load;
            if (in_valid && !flush) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mis_d       = 1'b0;
        end
    end

    // WB registers with synchronous reset overriding stall and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            mis_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            mis_q       <= mis_d;
            cnt_q       <= cnt_d;
        end
    end

    assign wb_valid        = valid_q;
    assign wb_reg_write    = reg_write_q;
    assign wb_rd           = rd_q;
    assign wb_data         = data_q;
    assign load_misaligned = mis_q;
    assign instr_count     = cnt_q;

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Pipeline register and writeback selector between the memory stage and the register file. It captures the memory-stage result at each enabled clock edge. For loads, it extracts and sign- or zero-extends the addressed byte or halfword from the raw data-memory word. It then selects the writeback value (ALU, load, or PC+4) and drives the register-file write port and the WB-stage forwarding path. It also flags misaligned loads and counts instructions entering writeback.

## Interface
Parameters
- OPERAND_WIDTH, 32 (from common): datapath width.
- CNT_WIDTH, 64: width of the instruction counter.

Ports
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  memory stage holds a valid instruction.
- stall  in  1  hold all WB registers.
- flush  in  1  squash the instruction being captured.
- ctrl_reg_write  in  1  instruction writes rd.
- ctrl_wb_sel  in  2  writeback source: 00 ALU, 01 MEM, 10 PC+4, 11 ALU.
- ctrl_load_size  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- rd_addr  in  5  destination register.
- alu_result  in  OPERAND_WIDTH  ALU result, or load address for loads.
- mem_data  in  32  raw word from data memory at the word containing alu_result.
- pc_plus4  in  OPERAND_WIDTH  link value.
- wb_valid  out  1  WB holds a valid instruction.
- wb_reg_write  out  1  register-file write enable.
- wb_rd  out  5  register-file write address.
- wb_data  out  OPERAND_WIDTH  register-file write data, also the forwarding data.
- load_misaligned  out  1  one-cycle pulse when a misaligned load is captured.
- instr_count  out  CNT_WIDTH  count of instructions entering WB.

## Operation
- Capture condition: rising edge with `!rst && !stall`.
  - On capture, all WB registers load new values.
  - If `stall`, every register holds, including the pulse output `load_misaligned`.
- Flush takes priority over capture:
  - If `flush && !stall`, load `wb_valid=0`, `wb_reg_write=0`, `load_misaligned=0`.
  - `flush && stall` also squashes: the same zeros are loaded.
- Byte offset is `off = alu_result[1:0]`.
  - LB/LBU: select byte `mem_data[8*off +: 8]`, then sign- or zero-extend.
  - LH/LHU: select halfword `mem_data[16*off[1] +: 16]`, then extend. Misaligned if `off[0]==1`.
  - LW: full word. Misaligned if `off!=0`.
  - Reserved codes 011/110/111: treated as LW.
- Misalignment applies only when `ctrl_wb_sel==01`.
  - A misaligned load raises `load_misaligned` and suppresses `wb_reg_write`.
  - `wb_valid` stays 1 for a misaligned load.
- Writeback value is computed before the register:
  - `ctrl_wb_sel` 00 or 11: `alu_result`.
  - 01: the aligned load value.
  - 10: `pc_plus4`.
- Register-file write enable: `wb_reg_write = in_valid & ctrl_reg_write & (rd_addr!=0) & !misaligned`.
- `wb_rd` and `wb_data` are captured even when invalid; consumers qualify them with `wb_reg_write`.
- `instr_count`:
  - Increments by 1 on each capture with `in_valid && !flush`, misaligned loads included.
  - Wraps modulo 2^CNT_WIDTH.

## Timing
- One-cycle latency: inputs sampled at edge N are visible on outputs after edge N.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values, applied at the edge where `rst=1`: all outputs 0, including `instr_count`. Reset overrides stall and flush.
- Reset mid-stall discards the held instruction.
- `load_misaligned` is high for exactly one capture.
  - If the next edge is stalled, it stays high until the next capture, matching the held instruction.
- The register file writes on the edge following `wb_reg_write=1`.
  - The forwarding consumer uses `wb_data` in the same cycle it is presented.

## Structure
- Add to package `common`:
  - `wb_sel_e` enum (WB_ALU, WB_MEM, WB_PC4).
  - `load_size_e` enum (LS_B=3'b000, LS_H=3'b001, LS_W=3'b010, LS_BU=3'b100, LS_HU=3'b101).
  - Reuse OPERAND_WIDTH from `common`.
- One combinational sub-module, `load_align`:
  - Inputs: `mem_data`, `off`, `load_size`.
  - Outputs: `data`, `misaligned`.
  - It is reusable by the memory stage's own load path.
- The top module holds only the pipeline registers, the writeback mux and the counter.

## Test plan
- LB at `alu_result=0x103` with `mem_data=0x80FF_1234`, `rd=5` → next cycle `wb_data=0xFFFF_FF80`, `wb_reg_write=1`, `wb_rd=5`. The same access as LBU → `0x0000_0080`.
- LH at `off=2` with `mem_data=0x8001_7FFF` → `0xFFFF_8001`. LHU at `off=0` → `0x0000_7FFF`. LH at `off=1` → `load_misaligned=1`, `wb_reg_write=0`, `instr_count` +1.
- JAL with `ctrl_wb_sel=10`, `pc_plus4=0x0000_0044`, `rd=1` → `wb_data=0x44`. The same instruction with `rd=0` → `wb_reg_write=0`, `wb_valid=1`.
- Capture an ALU result 0x55, then hold `stall=1` for 3 cycles while inputs change → outputs hold 0x55 and `instr_count` is unchanged. Release the stall → the new instruction appears after 1 cycle.
- `flush=1` with `in_valid=1` → `wb_valid=0`, `wb_reg_write=0`, counter unchanged. `flush` together with `stall` → same result. Assert `rst` during a held stall → all outputs 0 after the edge.
- Preload `instr_count` near `2^CNT_WIDTH-1` (use CNT_WIDTH=4), then issue 3 valid captures → the counter wraps 15→0→1.
